// File: rtl/keyboard_pkg.sv
// ---------------------------------------------------------------------------
// keyboard_pkg
// Shared definitions for the keyboard tone engine:
//   MAX_KEYS     - largest supported key count (note table length)
//   note_idx_t   - 4-bit note / key index
//   NOTE_HZ      - note frequency table, key i plays NOTE_HZ[i]
//   half_period  - clock cycles per half tone period, truncated
//   lowest_set   - index of the lowest set bit of a key vector
// ---------------------------------------------------------------------------
package keyboard_pkg;

   localparam int MAX_KEYS = 16;

   typedef logic [3:0] note_idx_t;

   localparam int NOTE_HZ [MAX_KEYS] = '{
      262, 294, 330, 349, 392, 440, 494, 523,
      587, 659, 698, 784, 880, 988, 1047, 1175
   };

   function automatic int half_period(input int clk_hz, input int idx);
      return clk_hz / (2 * NOTE_HZ[idx]);
   endfunction

   // Lowest set bit wins; returns 0 for an empty vector (callers guard that).
   function automatic note_idx_t lowest_set(input logic [MAX_KEYS-1:0] v);
      note_idx_t idx;
      idx = '0;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = note_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keyboard_tone_gen_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser plus stable-count debouncer for one active-low key.
// Parameter:
//   DEBOUNCE_CYCLES - consecutive differing samples needed to accept a change
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   raw_n   - raw push-button, 0 = pressed
//   pressed - debounced state, 1 = pressed
// ---------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic pressed
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          state_reg;
   logic [CW-1:0] cnt_reg;

   // The synchroniser stores the inverted (active-high) level so that its
   // reset value of 0 reads as "released" and cannot start a false press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         state_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= ~raw_n;
         sync2_reg <= sync1_reg;
         if (sync2_reg == state_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            state_reg <= ~state_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign pressed = state_reg;

endmodule

// File: rtl/keyboard_tone_gen.sv
// ---------------------------------------------------------------------------
// keyboard_tone_gen
// Key-to-tone engine: debounces NUM_KEYS buttons, picks one note by priority,
// and drives a gated square wave whose half-period comes from an
// elaboration-time table, shifted right by the runtime octave input.
// Optional feature (macro SUSTAIN_EN): gate is held for SUSTAIN_CYCLES after
// the last key is released, continuing the last tone.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   key_n      - raw buttons, 0 = pressed
//   octave     - right shift of the half-period (0..3)
//   led        - debounced key states, 1 = pressed
//   note_valid - a note is selected
//   note_idx   - selected key index
//   gate       - tone enabled
//   beep       - buzzer drive, registered gate & square wave
// ---------------------------------------------------------------------------
module keyboard_tone_gen
   import keyboard_pkg::*;
#(
   parameter int NUM_KEYS        = 8,
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int PRIORITY_LAST   = 1,
   parameter int SUSTAIN_CYCLES  = 25_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_n,
   input  logic [1:0]          octave,
   output logic [NUM_KEYS-1:0] led,
   output logic                note_valid,
   output logic [3:0]          note_idx,
   output logic                gate,
   output logic                beep
);
   // Lowest note has the longest half-period, so it sets the counter width.
   localparam int TW = $clog2(half_period(CLK_HZ, 0) + 1);

   if (NUM_KEYS < 1 || NUM_KEYS > MAX_KEYS || DEBOUNCE_CYCLES < 2 ||
       SUSTAIN_CYCLES < 1) begin : g_bad_config
      $error("keyboard_tone_gen: parameter out of range");
   end

   logic [NUM_KEYS-1:0] led_now;
   logic [NUM_KEYS-1:0] led_d_reg;
   logic [MAX_KEYS-1:0] held;
   logic [MAX_KEYS-1:0] rise;
   note_idx_t           idx_reg;
   note_idx_t           idx_next;
   logic                valid_reg;
   logic                valid_next;
   logic                gate_reg;
   logic                gate_next;
   logic                restart;
   logic                sq_reg;
   logic                beep_reg;
   logic [TW-1:0]       tone_cnt_reg;
   logic [TW-1:0]       hp_sel;
   logic [TW-1:0]       hp_shift;
   logic [TW-1:0]       reload_val;
   logic [TW-1:0]       hp_rom [MAX_KEYS];

   // -------------------------------------------------------------- keys
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_n   (key_n[gi]),
         .pressed (led_now[gi])
      );
   end

   // Constant half-period table; synthesises to a small ROM/mux.
   for (genvar gi = 0; gi < MAX_KEYS; gi++) begin : g_hp
      assign hp_rom[gi] = TW'(half_period(CLK_HZ, gi));
   end

   // --------------------------------------------------------- selection
   assign held = MAX_KEYS'(led_now);
   assign rise = MAX_KEYS'(led_now & ~led_d_reg);

   always_comb begin
      valid_next = |held;
      idx_next   = idx_reg;
      if (PRIORITY_LAST == 0) begin
         if (|held) idx_next = lowest_set(held);
      end else begin
         if (|rise) begin
            idx_next = lowest_set(rise);
         end else if (|held && !held[idx_reg]) begin
            // Current key let go while others are still down.
            idx_next = lowest_set(held);
         end
      end
   end

   // ------------------------------------------------------------ sustain
`ifdef SUSTAIN_EN
   localparam int SW = $clog2(SUSTAIN_CYCLES + 1);

   logic          tail_reg;
   logic [SW-1:0] tail_cnt_reg;

   // The tail starts on the falling edge of note_valid; the count is the
   // number of further cycles gate stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tail_reg     <= 1'b0;
         tail_cnt_reg <= '0;
      end else if (valid_next) begin
         tail_reg     <= 1'b0;
         tail_cnt_reg <= '0;
      end else if (valid_reg) begin
         tail_reg     <= 1'b1;
         tail_cnt_reg <= SW'(SUSTAIN_CYCLES - 1);
      end else if (tail_reg) begin
         if (tail_cnt_reg == '0) tail_reg <= 1'b0;
         else                    tail_cnt_reg <= tail_cnt_reg - 1'b1;
      end
   end

   assign gate_next = valid_next | valid_reg | (tail_reg & (tail_cnt_reg != '0));
`else
   assign gate_next = valid_next;
`endif

   // --------------------------------------------------------------- tone
   // A new note, a gate rise or a fresh press restarts the phase.
   assign restart = (idx_next != idx_reg) | (gate_next & ~gate_reg) |
                    (valid_next & ~valid_reg);

   // octave only matters here, i.e. it is sampled at (re)load time.
   always_comb begin
      hp_sel     = hp_rom[idx_next];
      hp_shift   = hp_sel >> octave;
      reload_val = (hp_shift >= TW'(2)) ? hp_shift - TW'(1) : TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_d_reg    <= '0;
         idx_reg      <= '0;
         valid_reg    <= 1'b0;
         gate_reg     <= 1'b0;
         tone_cnt_reg <= '0;
         sq_reg       <= 1'b0;
         beep_reg     <= 1'b0;
      end else begin
         led_d_reg <= led_now;
         idx_reg   <= idx_next;
         valid_reg <= valid_next;
         gate_reg  <= gate_next;
         if (restart) begin
            tone_cnt_reg <= reload_val;
            sq_reg       <= 1'b0;
         end else if (tone_cnt_reg == '0) begin
            tone_cnt_reg <= reload_val;
            sq_reg       <= ~sq_reg;
         end else begin
            tone_cnt_reg <= tone_cnt_reg - 1'b1;
         end
         beep_reg <= gate_reg & sq_reg;
      end
   end

   assign led        = led_now;
   assign note_valid = valid_reg;
   assign note_idx   = idx_reg;
   assign gate       = gate_reg;
   assign beep       = beep_reg;

endmodule
